enybul_app: RTL and testbench
=============================

// Module: enybul_app
// PURPOSE
//   Enemy-bullet controller, downstream of enytank_app. Accepts a fire request from the
//   enemy tank, spawns a bullet at the tank position and moves it one grid cell per
//   step_tick in the tank's facing direction. Retires the bullet on a map edge or on a
//   hit of my tank. Returns the bullet-in-flight flag as enybul_state_feedback.
// PARAMETERS
//   X_MAX       24  last valid grid column; legal x is 0..X_MAX
//   Y_MAX       12  last valid grid row; legal y is 0..Y_MAX
//   COOL_TICKS  2   step_ticks spent in COOL before a new fire request is accepted (>=1)
// PORTS
//   clk                    in   1  system clock; the only clock
//   rst                    in   1  asynchronous, active-high reset
//   enable                 in   1  global game-mode enable
//   step_tick              in   1  single-clk pulse, 8 Hz, bullet move strobe
//   fire_req               in   1  enybul_state from enytank_app (level)
//   enytank_xpos/ypos      in   5  enemy tank grid position
//   enytank_dir            in   2  enemy tank facing: 00 up, 01 down, 10 left, 11 right
//   mytank_xpos/ypos       in   5  player tank grid position
//   reward_frozen          in   1  freeze reward active (used only with ENYBUL_FREEZE_EN)
//   enybul_x/enybul_y      out  5  bullet position; 5'h1F/5'h1F (PARK) when not flying
//   enybul_state_feedback  out  1  1 while state==FLY
//   enybul_dir             out  2  latched flight direction
//   hit_mytank             out  1  one-clk pulse when the bullet hits my tank
// BEHAVIOUR
//   Reset: state=IDLE, enybul_x=enybul_y=5'h1F, feedback=0, enybul_dir=00, hit_mytank=0, cool_cnt=0.
//   enable=0: synchronous return to IDLE with the reset output values. Applies mid-flight too.
//   States:
//   - IDLE: fire_req=1 at edge N -> FLY. At N, load x/y from enytank pos and dir from
//     enytank_dir. Feedback is 1 from N+1. One-cycle latency.
//   - FLY: each clk, compare bullet to mytank position first (spawn cell included).
//     On a match: hit_mytank=1 for one clk, then COOL; no move that cycle (hit beats step).
//     Otherwise on step_tick: compute next cell. Off-grid means up at y=0, down at y=Y_MAX,
//     left at x=0 or right at x=X_MAX; go to COOL with no hit. Else move.
//     Direction is frozen for the whole flight; later enytank_dir changes are ignored.
//   - COOL: on entry, park position and clear feedback. cool_cnt counts step_ticks;
//     at COOL_TICKS go to IDLE and clear cnt. fire_req is ignored in COOL.
//     A fire_req still held high on IDLE entry fires the next clk.
//   Arithmetic: 5-bit unsigned. Bounds are checked before the +/-1, so the value never wraps.
//   Next-state priority in FLY: enable=0 > hit > off-grid > move.
//   Reset asserted mid-flight clears state immediately, without waiting for clk.
// CONFIGURATION
//   ENYBUL_FREEZE_EN defined: in FLY, reward_frozen=1 suppresses moves on step_tick.
//     Hit detection stays live, and COOL still counts.
//   Undefined: reward_frozen is ignored and bullets always move.
// STRUCTURE
//   enybul_pkg: DIR_UP/DOWN/LEFT/RIGHT codes, PARK_POS=5'h1F, state encoding
//   (IDLE=2'd0, FLY=2'd1, COOL=2'd2).
//   Sub-module enybul_step (combinational): in x,y,dir,X_MAX,Y_MAX; out nx,ny,off_grid.
//   Used by FLY and reusable for the player-bullet block.
//   Top: state register, cool counter, output registers.
// TESTING
//   1 Tank (5,5) dir 11, fire_req=1, me at (20,0): feedback=1 next clk. x=6,7,...,24
//     on successive ticks; at x=24 the next tick goes to COOL with pos 1F/1F, feedback=0,
//     hit never.
//   2 Tank (3,8) dir 00, me at (3,4): ticks give y=7,6,5,4; hit_mytank pulses exactly
//     1 clk when y=4, no further move, feedback=0 next clk.
//   3 Tank at (0,0) dir 10: first tick is off-grid, so COOL with no underflow to 31.
//     fire_req held high re-fires exactly after 2 ticks (COOL_TICKS=2).
//   4 Mid-flight at (10,6): assert rst async -> outputs 1F/1F/0 before next clk.
//     Same with enable=0 -> IDLE on next clk.
//   5 ENYBUL_FREEZE_EN, flight at (8,3) dir 01, reward_frozen=1 for 4 ticks: y stays 3.
//     Me moved onto (8,3) -> hit pulses. Without the macro, y advances to 7.
//   6 Simultaneous step_tick and hit in the same clk: hit reported, position unchanged.

Source files
------------

// File: rtl/enybul_pkg.sv
// rtl/enybul_pkg.sv - shared direction codes, FSM encoding and park position for the enemy bullet
package enybul_pkg;

   typedef enum logic [1:0] {
      DIR_UP    = 2'b00,
      DIR_DOWN  = 2'b01,
      DIR_LEFT  = 2'b10,
      DIR_RIGHT = 2'b11
   } dir_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FLY  = 2'd1,
      COOL = 2'd2
   } state_t;

   localparam logic [4:0] PARK_POS = 5'h1F;

endpackage

// File: rtl/enybul_if.sv
// rtl/enybul_if.sv - tank/game inputs and bullet outputs of the enemy-bullet controller
interface enybul_if;
   logic       enable;
   logic       step_tick;
   logic       fire_req;
   logic [4:0] enytank_xpos;
   logic [4:0] enytank_ypos;
   logic [1:0] enytank_dir;
   logic [4:0] mytank_xpos;
   logic [4:0] mytank_ypos;
   logic       reward_frozen;
   logic [4:0] enybul_x;
   logic [4:0] enybul_y;
   logic       enybul_state_feedback;
   logic [1:0] enybul_dir;
   logic       hit_mytank;

   modport master (
      output enable, step_tick, fire_req, enytank_xpos, enytank_ypos, enytank_dir,
             mytank_xpos, mytank_ypos, reward_frozen,
      input  enybul_x, enybul_y, enybul_state_feedback, enybul_dir, hit_mytank
   );

   modport slave (
      input  enable, step_tick, fire_req, enytank_xpos, enytank_ypos, enytank_dir,
             mytank_xpos, mytank_ypos, reward_frozen,
      output enybul_x, enybul_y, enybul_state_feedback, enybul_dir, hit_mytank
   );
endinterface

// File: rtl/enybul_step.sv
// rtl/enybul_step.sv - combinational one-cell grid step with off-grid detection
import enybul_pkg::*;

module enybul_step #(
   parameter int X_MAX = 24,
   parameter int Y_MAX = 12
) (
   input  logic [4:0] x,
   input  logic [4:0] y,
   input  dir_t       dir,
   output logic [4:0] nx,
   output logic [4:0] ny,
   output logic       off_grid
);

   // Edges are tested before the +/-1 so the result never wraps.
   always_comb begin
      nx       = x;
      ny       = y;
      off_grid = 1'b0;
      unique case (dir)
         DIR_UP:    if (y == 5'd0)         off_grid = 1'b1; else ny = y - 5'd1;
         DIR_DOWN:  if (y >= 5'(Y_MAX))    off_grid = 1'b1; else ny = y + 5'd1;
         DIR_LEFT:  if (x == 5'd0)         off_grid = 1'b1; else nx = x - 5'd1;
         DIR_RIGHT: if (x >= 5'(X_MAX))    off_grid = 1'b1; else nx = x + 5'd1;
         default:   off_grid = 1'b1;
      endcase
   end

endmodule

// File: rtl/enybul_app.sv
// rtl/enybul_app.sv - enemy-bullet controller: fire, fly, hit/edge retire, cool-down
// Optional ENYBUL_FREEZE_EN: reward_frozen holds the bullet still while in flight.
import enybul_pkg::*;

module enybul_app #(
   parameter int X_MAX      = 24,
   parameter int Y_MAX      = 12,
   parameter int COOL_TICKS = 2
) (
   input  logic   clk,
   input  logic   rst,
   enybul_if.slave bus
);

   localparam int CW = $clog2(COOL_TICKS + 1);

   state_t          state, next_state;
   logic [4:0]      x_q, y_q, x_d, y_d;
   dir_t            dir_q, dir_d;
   logic            hit_q, hit_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [4:0]      nx, ny;
   logic            off_grid;
   logic            match;
   logic            move_tick;
   logic            cool_done;

   enybul_step #(.X_MAX(X_MAX), .Y_MAX(Y_MAX)) u_step (
      .x        (x_q),
      .y        (y_q),
      .dir      (dir_q),
      .nx       (nx),
      .ny       (ny),
      .off_grid (off_grid)
   );

   assign match     = (x_q == bus.mytank_xpos) && (y_q == bus.mytank_ypos);
   assign cool_done = bus.step_tick && (cnt_q == CW'(COOL_TICKS - 1));

`ifdef ENYBUL_FREEZE_EN
   assign move_tick = bus.step_tick && !bus.reward_frozen;
`else
   logic unused_frozen;
   assign unused_frozen = bus.reward_frozen;
   assign move_tick     = bus.step_tick;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Priority in flight: enable low, then hit, then off-grid, then move.
   always_comb begin
      next_state = state;
      if (!bus.enable) begin
         next_state = IDLE;
      end else begin
         unique case (state)
            IDLE:    if (bus.fire_req)             next_state = FLY;
            FLY:     if (match)                    next_state = COOL;
                     else if (move_tick && off_grid) next_state = COOL;
            COOL:    if (cool_done)                next_state = IDLE;
            default:                               next_state = IDLE;
         endcase
      end
   end

   always_comb begin
      x_d   = x_q;
      y_d   = y_q;
      dir_d = dir_q;
      hit_d = 1'b0;
      cnt_d = cnt_q;
      if (!bus.enable) begin
         x_d   = PARK_POS;
         y_d   = PARK_POS;
         dir_d = DIR_UP;
         cnt_d = '0;
      end else begin
         unique case (state)
            IDLE: begin
               cnt_d = '0;
               if (bus.fire_req) begin
                  x_d   = bus.enytank_xpos;
                  y_d   = bus.enytank_ypos;
                  dir_d = dir_t'(bus.enytank_dir);
               end
            end
            FLY: begin
               if (match) begin
                  hit_d = 1'b1;
                  x_d   = PARK_POS;
                  y_d   = PARK_POS;
                  cnt_d = '0;
               end else if (move_tick) begin
                  if (off_grid) begin
                     x_d   = PARK_POS;
                     y_d   = PARK_POS;
                     cnt_d = '0;
                  end else begin
                     x_d = nx;
                     y_d = ny;
                  end
               end
            end
            COOL: begin
               if (cool_done)          cnt_d = '0;
               else if (bus.step_tick) cnt_d = cnt_q + 1'b1;
            end
            default: begin
               x_d   = PARK_POS;
               y_d   = PARK_POS;
               cnt_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q   <= PARK_POS;
         y_q   <= PARK_POS;
         dir_q <= DIR_UP;
         hit_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         x_q   <= x_d;
         y_q   <= y_d;
         dir_q <= dir_d;
         hit_q <= hit_d;
         cnt_q <= cnt_d;
      end
   end

   assign bus.enybul_x              = x_q;
   assign bus.enybul_y              = y_q;
   assign bus.enybul_dir            = dir_q;
   assign bus.hit_mytank            = hit_q;
   assign bus.enybul_state_feedback = (state == FLY);

endmodule

// File: tb/tb_enybul_app.sv
// tb/tb_enybul_app.sv - directed self-checking bench for enybul_app
module tb_enybul_app;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic hit_seen;

   enybul_if bus ();

   enybul_app dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      bus.step_tick = 1'b1;
      cyc();
      bus.step_tick = 1'b0;
   endtask

   task automatic go_idle();
      bus.enable = 1'b0;
      cyc();
      bus.enable = 1'b1;
   endtask

   task automatic set_tank(input int x, input int y, input int d);
      bus.enytank_xpos = 5'(x);
      bus.enytank_ypos = 5'(y);
      bus.enytank_dir  = 2'(d);
   endtask

   task automatic set_me(input int x, input int y);
      bus.mytank_xpos = 5'(x);
      bus.mytank_ypos = 5'(y);
   endtask

   initial begin
      bus.enable        = 1'b1;
      bus.step_tick     = 1'b0;
      bus.fire_req      = 1'b0;
      bus.reward_frozen = 1'b0;
      set_tank(0, 0, 0);
      set_me(20, 0);
      #2 rst = 1'b1;
      #2;
      chk("rst_x",   bus.enybul_x, 32'h1F);
      chk("rst_y",   bus.enybul_y, 32'h1F);
      chk("rst_fb",  bus.enybul_state_feedback, 32'd0);
      chk("rst_dir", bus.enybul_dir, 32'd0);
      chk("rst_hit", bus.hit_mytank, 32'd0);
      cyc();
      rst = 1'b0;
      cyc();

      // 1: fly right to the edge and retire without a hit
      set_tank(5, 5, 3);
      set_me(20, 0);
      bus.fire_req = 1'b1;
      cyc();
      bus.fire_req = 1'b0;
      bus.enytank_dir = 2'd0;
      chk("t1_fb", bus.enybul_state_feedback, 32'd1);
      chk("t1_x0", bus.enybul_x, 32'd5);
      chk("t1_dir", bus.enybul_dir, 32'd3);
      hit_seen = 1'b0;
      for (int e = 6; e <= 24; e++) begin
         tick();
         hit_seen |= bus.hit_mytank;
         chk($sformatf("t1_x%0d", e), bus.enybul_x, 32'(e));
      end
      chk("t1_y", bus.enybul_y, 32'd5);
      tick();
      hit_seen |= bus.hit_mytank;
      chk("t1_edge_x",  bus.enybul_x, 32'h1F);
      chk("t1_edge_y",  bus.enybul_y, 32'h1F);
      chk("t1_edge_fb", bus.enybul_state_feedback, 32'd0);
      chk("t1_nohit",   hit_seen, 32'd0);
      go_idle();

      // 2: fly up onto my tank, one-clock hit pulse
      set_tank(3, 8, 0);
      set_me(3, 4);
      bus.fire_req = 1'b1;
      cyc();
      bus.fire_req = 1'b0;
      chk("t2_y8", bus.enybul_y, 32'd8);
      for (int e = 7; e >= 4; e--) begin
         tick();
         chk($sformatf("t2_y%0d", e), bus.enybul_y, 32'(e));
         chk($sformatf("t2_hit_y%0d", e), bus.hit_mytank, 32'd0);
      end
      cyc();
      chk("t2_hit",   bus.hit_mytank, 32'd1);
      chk("t2_fb",    bus.enybul_state_feedback, 32'd0);
      chk("t2_park",  bus.enybul_y, 32'h1F);
      cyc();
      chk("t2_hit_end", bus.hit_mytank, 32'd0);
      go_idle();

      // 3: off-grid on the first tick, refire after the cool-down
      set_tank(0, 0, 2);
      set_me(20, 12);
      bus.fire_req = 1'b1;
      cyc();
      chk("t3_fb", bus.enybul_state_feedback, 32'd1);
      tick();
      chk("t3_cool_fb", bus.enybul_state_feedback, 32'd0);
      chk("t3_x",       bus.enybul_x, 32'h1F);
      chk("t3_y",       bus.enybul_y, 32'h1F);
      cyc();
      cyc();
      chk("t3_cool_hold", bus.enybul_state_feedback, 32'd0);
      tick();
      chk("t3_cool1", bus.enybul_state_feedback, 32'd0);
      tick();
      chk("t3_idle",  bus.enybul_state_feedback, 32'd0);
      cyc();
      chk("t3_refire", bus.enybul_state_feedback, 32'd1);
      chk("t3_rex",    bus.enybul_x, 32'd0);
      chk("t3_rey",    bus.enybul_y, 32'd0);
      bus.fire_req = 1'b0;
      go_idle();

      // 4: async reset mid-flight, then enable drop mid-flight
      set_tank(10, 6, 3);
      set_me(0, 0);
      bus.fire_req = 1'b1;
      cyc();
      bus.fire_req = 1'b0;
      chk("t4_x", bus.enybul_x, 32'd10);
      #3 rst = 1'b1;
      #1;
      chk("t4_rst_x",  bus.enybul_x, 32'h1F);
      chk("t4_rst_y",  bus.enybul_y, 32'h1F);
      chk("t4_rst_fb", bus.enybul_state_feedback, 32'd0);
      #1 rst = 1'b0;
      cyc();
      bus.fire_req = 1'b1;
      cyc();
      bus.fire_req = 1'b0;
      chk("t4_en_fb1", bus.enybul_state_feedback, 32'd1);
      bus.enable = 1'b0;
      cyc();
      chk("t4_en_fb0", bus.enybul_state_feedback, 32'd0);
      chk("t4_en_x",   bus.enybul_x, 32'h1F);
      chk("t4_en_dir", bus.enybul_dir, 32'd0);
      bus.enable = 1'b1;
      cyc();

      // 5: reward_frozen during flight
      set_tank(8, 3, 1);
      set_me(0, 0);
      bus.reward_frozen = 1'b1;
      bus.fire_req = 1'b1;
      cyc();
      bus.fire_req = 1'b0;
      for (int i = 0; i < 4; i++) tick();
`ifdef ENYBUL_FREEZE_EN
      chk("t5_y", bus.enybul_y, 32'd3);
      set_me(8, 3);
`else
      chk("t5_y", bus.enybul_y, 32'd7);
      set_me(8, 7);
`endif
      bus.reward_frozen = 1'b0;
      cyc();
      chk("t5_hit", bus.hit_mytank, 32'd1);
      go_idle();

      // 6: step_tick and hit in the same clock
      set_tank(15, 10, 0);
      set_me(15, 9);
      bus.fire_req = 1'b1;
      cyc();
      bus.fire_req = 1'b0;
      tick();
      chk("t6_y9",    bus.enybul_y, 32'd9);
      chk("t6_nohit", bus.hit_mytank, 32'd0);
      tick();
      chk("t6_hit",  bus.hit_mytank, 32'd1);
      chk("t6_y",    bus.enybul_y, 32'h1F);
      chk("t6_fb",   bus.enybul_state_feedback, 32'd0);
      go_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
